// File: rtl/dac_stream_pkg.sv
// Shared definitions for the DAC sample output stage.
//   DEF_*         default parameter values for dac_stream
//   CH_LEFT/RIGHT channel index of the left/right sample inside a frame
//   UNDERRUN_MAX  saturation value of the underrun counter
//   sat_inc16     saturating 16-bit increment
package dac_stream_pkg;

  localparam int DEF_WIDTH      = 4;
  localparam int DEF_CHANNELS   = 2;
  localparam int DEF_SAMPLE_DIV = 656;
  localparam int DEF_DEPTH      = 8;

  localparam int CH_LEFT  = 0;
  localparam int CH_RIGHT = 1;

  localparam logic [15:0] UNDERRUN_MAX = 16'hFFFF;

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == UNDERRUN_MAX) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/dac_stream_sample_fifo.sv
// Synchronous frame FIFO with zero read latency.
//   clk, reset  rising-edge clock, synchronous active-high reset
//   push        write push_data this edge (ignored when full)
//   push_data   frame to store
//   pop         drop the head frame this edge (ignored when empty)
//   head        oldest stored frame, visible combinationally
//   level       frames held, 0..DEPTH
// The level is an explicit counter; pointers simply wrap modulo DEPTH,
// which is a power of two.
module sample_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok = push && (level < LW'(DEPTH));
  assign pop_ok  = pop && (level != '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      if (push_ok && !pop_ok)      level <= level + LW'(1);
      else if (pop_ok && !push_ok) level <= level - LW'(1);
    end
  end

  // Storage carries no reset: a frame is only ever read after being written.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/dac_stream.sv
// N-channel audio sample output stage.
//   clk, reset      rising-edge clock, synchronous active-high reset
//   enable          run the sample divider and PWM; low pauses playback
//   in_valid/ready  producer frame handshake
//   in_data         frame, channel c at [c*WIDTH +: WIDTH]
//   sample_tick     one-cycle pulse on the cycle out_sample was updated
//   out_sample      current samples, same packing as in_data
//   pwm_out         per-channel first-order PWM bit
//   fifo_level      frames buffered, 0..DEPTH
//   underrun_count  ticks that found the FIFO empty, saturating
//
// Handshake: a frame transfers on every rising edge where in_valid and
// in_ready are both high. in_ready depends only on reset and the pre-edge
// level, never on in_valid, so a full FIFO refuses a frame even on an edge
// that also pops one.
module dac_stream
  import dac_stream_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int CHANNELS   = DEF_CHANNELS,
  parameter int SAMPLE_DIV = DEF_SAMPLE_DIV,
  parameter int DEPTH      = DEF_DEPTH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [CHANNELS*WIDTH-1:0]     in_data,
  output logic                          sample_tick,
  output logic [CHANNELS*WIDTH-1:0]     out_sample,
  output logic [CHANNELS-1:0]           pwm_out,
  output logic [$clog2(DEPTH):0]        fifo_level,
  output logic [15:0]                   underrun_count
);

  localparam int FW = CHANNELS * WIDTH;
  localparam int DW = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
  localparam int LW = $clog2(DEPTH) + 1;

  logic [DW-1:0]    div_cnt;
  logic             tick;
  logic             push;
  logic             pop;
  logic             have_frame;
  logic [FW-1:0]    head;
  logic [WIDTH-1:0] pwm_cnt;
  logic [CHANNELS-1:0] pwm_next;

  assign in_ready   = !reset && (fifo_level < LW'(DEPTH));
  assign push       = in_valid && in_ready;
  assign have_frame = (fifo_level != '0);
  assign tick       = enable && (div_cnt == DW'(SAMPLE_DIV - 1));
  // A frame pushed on a tick edge into an empty FIFO is not yet at the head,
  // so that tick is an underrun.
  assign pop        = tick && have_frame;

  sample_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (in_data),
    .pop       (pop),
    .head      (head),
    .level     (fifo_level)
  );

  // Sample-period divider; drops back to 0 whenever playback is paused so the
  // first tick after resuming is a full period away.
  always_ff @(posedge clk) begin
    if (reset || !enable || tick) div_cnt <= '0;
    else                          div_cnt <= div_cnt + DW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sample_tick    <= 1'b0;
      out_sample     <= '0;
      underrun_count <= '0;
    end else begin
      sample_tick <= tick;
      if (tick) begin
        if (have_frame) begin
          out_sample <= head;
        end else begin
          out_sample     <= '0;
          underrun_count <= sat_inc16(underrun_count);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || !enable) pwm_cnt <= '0;
    else                  pwm_cnt <= pwm_cnt + WIDTH'(1);
  end

  // Sample s is high for s of every 2^WIDTH counter values.
  for (genvar c = 0; c < CHANNELS; c++) begin : g_pwm
    assign pwm_next[c] = enable && (pwm_cnt < out_sample[c*WIDTH +: WIDTH]);
  end

  always_ff @(posedge clk) begin
    if (reset) pwm_out <= '0;
    else       pwm_out <= pwm_next;
  end

endmodule
